// File: rtl/freq_meter_pkg.sv
`default_nettype none
//============================================================================
// Module : freq_meter_pkg
// Shared types, defaults and helpers for the frequency / duty meter.
// Rev    : 1.0
//============================================================================
package freq_meter_pkg;

    localparam int c_DEFAULT_DATA_WIDTH  = 8;
    localparam int c_DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    // Largest count representable in a counter of the given width.
    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
//============================================================================
// Module : sync_edge_det
// Multi-flop synchronizer with a trailing delay flop and rising-edge detect.
// Rev    : 1.0
//============================================================================
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = c_DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_s_d  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_s    = r_sync[SYNC_STAGES-1];
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_s_d;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
//============================================================================
// Module : freq_meter
// Measures period and high time of a slow signal in clk cycles.
// Rev    : 1.0
//============================================================================
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int DATA_WIDTH  = c_DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = c_DEFAULT_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sig_in,
    output logic [DATA_WIDTH-1:0] period,
    output logic [DATA_WIDTH-1:0] high_time,
    output logic                  valid,
    output logic                  overflow,
    output logic                  busy
);

    localparam logic [DATA_WIDTH-1:0] c_CNT_MAX = DATA_WIDTH'(cnt_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] c_ONE     = DATA_WIDTH'(1);

    logic                  w_s;
    logic                  w_rise;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_hi_cnt;
    logic [DATA_WIDTH-1:0] r_period;
    logic [DATA_WIDTH-1:0] r_high_time;
    logic                  r_valid;
    logic                  r_overflow;
    logic                  r_busy;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk     (clk),
        .rst     (rst),
        .i_async (sig_in),
        .o_s     (w_s),
        .o_rise  (w_rise)
    );

    // Disable has priority over everything, including a coincident rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_hi_cnt    <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!en) begin
                r_state    <= IDLE;
                r_cnt      <= '0;
                r_hi_cnt   <= '0;
                r_overflow <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state  <= ARM;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_hi_cnt <= '0;
                    end
                    ARM: begin
                        r_busy <= 1'b1;
                        if (w_rise) begin
                            r_cnt    <= c_ONE;
                            r_hi_cnt <= c_ONE;
                            r_state  <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        r_busy <= 1'b1;
                        // A rise on the saturating cycle still yields a full-scale result.
                        if (w_rise) begin
                            r_period    <= r_cnt;
                            r_high_time <= r_hi_cnt;
                            r_valid     <= 1'b1;
                            r_overflow  <= 1'b0;
                            r_cnt       <= c_ONE;
                            r_hi_cnt    <= c_ONE;
                        end else if (r_cnt == c_CNT_MAX) begin
                            r_overflow <= 1'b1;
                            r_state    <= ARM;
                            r_cnt      <= '0;
                            r_hi_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                            if (w_s) begin
                                r_hi_cnt <= r_hi_cnt + c_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_high_time;
    assign valid     = r_valid;
    assign overflow  = r_overflow;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
//============================================================================
// Module : tb_freq_meter
// Self-checking bench for freq_meter against a timestamp-based reference.
// Rev    : 1.0
//============================================================================
module tb_freq_meter;

    localparam int DW   = 8;
    localparam int SS   = 2;
    localparam int MAXC = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sig_in;
    logic [DW-1:0] period;
    logic [DW-1:0] high_time;
    logic          valid;
    logic          overflow;
    logic          busy;

    always #5 clk = ~clk;

    freq_meter #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .overflow  (overflow),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: sig_in value captured at each clock edge, plus the edge index
    // of the last accepted rise. Results come from edge-index differences and
    // a count of high samples over the window.
    bit            xs [0:65535];
    int            n         = 0;
    int            rst_floor = 0;
    int            mode      = 0;   // 0 disabled, 1 waiting for rise, 2 timing
    int            t_last    = 0;
    logic [DW-1:0] e_period  = '0;
    logic [DW-1:0] e_high    = '0;
    logic          e_valid   = 1'b0;
    logic          e_ovf     = 1'b0;
    logic          e_busy    = 1'b0;
    int            phase     = 0;
    int            n_vld     = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit xv(input int k);
        if (k < rst_floor || k < 0) return 1'b0;
        return xs[k];
    endfunction

    task automatic tick(input bit sig, input bit e);
        bit s_now;
        bit rise;
        int hi;
        sig_in = sig;
        en     = e;
        @(posedge clk);
        n++;
        xs[n]   = sig;
        s_now   = xv(n - SS);
        rise    = s_now & ~xv(n - SS - 1);
        e_valid = 1'b0;
        if (!e) begin
            mode  = 0;
            e_ovf = 1'b0;
        end else if (mode == 0) begin
            mode = 1;
        end else if (mode == 1) begin
            if (rise) begin
                t_last = n;
                mode   = 2;
            end
        end else if (rise) begin
            hi = 0;
            for (int k = t_last; k < n; k++) hi += int'(xv(k - SS));
            e_period = DW'(n - t_last);
            e_high   = DW'(hi);
            e_valid  = 1'b1;
            e_ovf    = 1'b0;
            t_last   = n;
        end else if (n - t_last == MAXC) begin
            e_ovf = 1'b1;
            mode  = 1;
        end
        e_busy = (mode != 0);
        #1;
        if (valid === 1'b1) n_vld++;
        chk("valid",     int'(valid),     int'(e_valid));
        chk("busy",      int'(busy),      int'(e_busy));
        chk("overflow",  int'(overflow),  int'(e_ovf));
        chk("period",    int'(period),    int'(e_period));
        chk("high_time", int'(high_time), int'(e_high));
    endtask

    task automatic run_wave(input int p, input int h, input int cycles, input bit e,
                            input int cp, input int ch);
        for (int i = 0; i < cycles; i++) begin
            if (phase >= p) phase = 0;
            tick(phase < h, e);
            phase++;
            if (cp != 0 && valid === 1'b1) begin
                chk("const_period", int'(period), cp);
                chk("const_high",   int'(high_time), ch);
                chk("const_ovf",    int'(overflow), 0);
            end
        end
    endtask

    task automatic model_reset();
        mode     = 0;
        e_period = '0;
        e_high   = '0;
        e_valid  = 1'b0;
        e_ovf    = 1'b0;
        e_busy   = 1'b0;
    endtask

    int       na;
    int       waited;
    int       vstart;
    int       rp;
    int       rh;
    int       rlen;
    int       rkind;
    bit       ren;
    logic [DW-1:0] saved_p;

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        sig_in = 1'b0;
        #1;
        chk("rst_period",   int'(period),    0);
        chk("rst_high",     int'(high_time), 0);
        chk("rst_valid",    int'(valid),     0);
        chk("rst_overflow", int'(overflow),  0);
        chk("rst_busy",     int'(busy),      0);
        @(posedge clk); n++; xs[n] = 1'b0;
        @(posedge clk); n++; xs[n] = 1'b0;
        #2 rst = 1'b0;
        rst_floor = n + 1;
        model_reset();

        // Divide-by-4 then 7 then 10, settled results checked against constants.
        run_wave(4, 2, 12, 1'b1, 0, 0);
        run_wave(4, 2, 40, 1'b1, 4, 2);
        run_wave(7, 3, 20, 1'b1, 0, 0);
        run_wave(7, 3, 50, 1'b1, 7, 3);
        run_wave(10, 5, 25, 1'b1, 0, 0);
        run_wave(10, 5, 60, 1'b1, 10, 5);

        // Single rise, then held low: overflow after the full count.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        saved_p = e_period;
        tick(1'b1, 1'b1);
        na = n;
        tick(1'b1, 1'b1);
        waited = 0;
        while (overflow !== 1'b1 && waited < 400) begin
            tick(1'b0, 1'b1);
            waited++;
        end
        chk("ovf_latency", n - na, SS + MAXC);
        chk("ovf_period_hold", int'(period), int'(saved_p));
        chk("ovf_busy", int'(busy), 1);
        phase = 0;
        run_wave(8, 4, 40, 1'b1, 0, 0);
        chk("ovf_cleared", int'(overflow), 0);

        // Disable mid-period and re-enable.
        run_wave(6, 3, 25, 1'b1, 0, 0);
        run_wave(6, 3, 27, 1'b1, 6, 3);
        run_wave(6, 3, 1, 1'b0, 0, 0);
        chk("dis_busy",   int'(busy),   0);
        chk("dis_valid",  int'(valid),  0);
        chk("dis_period", int'(period), 6);
        run_wave(6, 3, 10, 1'b0, 0, 0);
        waited = 0;
        while (valid !== 1'b1 && waited < 100) begin
            run_wave(6, 3, 1, 1'b1, 0, 0);
            waited++;
        end
        chk("reen_period", int'(period), 6);
        chk("reen_wait_ge_period", int'(waited > 6), 1);

        // Asynchronous reset between clock edges.
        run_wave(5, 2, 20, 1'b1, 0, 0);
        run_wave(5, 2, 13, 1'b1, 5, 2);
        #3 rst = 1'b1;
        #1;
        chk("arst_period",   int'(period),    0);
        chk("arst_high",     int'(high_time), 0);
        chk("arst_valid",    int'(valid),     0);
        chk("arst_overflow", int'(overflow),  0);
        chk("arst_busy",     int'(busy),      0);
        model_reset();
        @(posedge clk); n++; xs[n] = 1'b0;
        @(posedge clk); n++; xs[n] = 1'b0;
        #2 rst = 1'b0;
        rst_floor = n + 1;
        run_wave(5, 2, 20, 1'b1, 0, 0);
        run_wave(5, 2, 30, 1'b1, 5, 2);

        // Full-scale period and one cycle beyond it.
        run_wave(255, 100, 300, 1'b1, 0, 0);
        vstart = n_vld;
        run_wave(255, 100, 800, 1'b1, 255, 100);
        chk("p255_valids_seen", int'(n_vld - vstart >= 2), 1);
        run_wave(256, 100, 300, 1'b1, 0, 0);
        vstart = n_vld;
        run_wave(256, 100, 700, 1'b1, 0, 0);
        chk("p256_no_valid", n_vld - vstart, 0);

        // Randomised waves, raw noise and enable drops.
        for (int seg = 0; seg < 24; seg++) begin
            rp    = int'($urandom_range(40, 2));
            rh    = int'($urandom_range(rp - 1, 1));
            rlen  = int'($urandom_range(150, 40));
            rkind = int'($urandom_range(3, 0));
            ren   = ($urandom_range(7, 0) != 0);
            if (rkind == 0) begin
                for (int i = 0; i < rlen; i++)
                    tick(1'($urandom_range(1, 0)), ($urandom_range(15, 0) != 0));
            end else begin
                run_wave(rp, rh, rlen, ren, 0, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
